// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store bus bridge.
package lsu_pkg;

  // Bridge FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Funct3 encodings for access size and sign.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  // Command captured from the core when an access starts.
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // True when the access size does not fit its natural alignment.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3)
      F3_LH, F3_LHU: return off[0];
      F3_LW:         return off != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and replicated store data for the
// bus, and lane selection with sign/zero extension for load data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // A halfword only ever uses Addr[1]; Addr[0] is ignored for lane choice.
  assign byte_lane = rdata_i[{off_i, 3'b000} +: 8];
  assign half_lane = rdata_i[{off_i[1], 4'b0000} +: 16];

  // Size-dependent enables, store replication and load extension.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    load_o  = rdata_i;
    case (funct3_i)
      F3_LB, F3_LBU: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        load_o  = funct3_i[2] ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      end
      F3_LH, F3_LHU: begin
        be_o    = 4'b0011 << {off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        load_o  = funct3_i[2] ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store unit bridging core memory strobes onto a valid/ready bus.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned H/W accesses
// (no bus traffic, MisalignErr pulse); otherwise offending offset bits are ignored.
module lsu_bus_bridge
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        BusErr,
  output logic        MisalignErr,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic [15:0] cnt_inc;
  logic        timeout;
  logic [3:0]  be_w;
  logic [31:0] wdata_w;
  logic [31:0] load_w;

`ifdef MISALIGN_TRAP_EN
  logic mis_err_q, mis_err_d;
  assign MisalignErr = mis_err_q;
`else
  assign MisalignErr = 1'b0;
`endif

  // Lane logic works on the latched command so bus fields stay stable in REQ.
  lsu_align u_align (
    .funct3_i (cmd_q.funct3),
    .off_i    (cmd_q.addr[1:0]),
    .wdata_i  (cmd_q.wdata),
    .rdata_i  (mem_rdata),
    .be_o     (be_w),
    .wdata_o  (wdata_w),
    .load_o   (load_w)
  );

  assign cnt_inc = cnt_q + 16'd1;
  assign timeout = (cnt_inc == TIMEOUT_LIM);

  // Bus request fields are only driven while the request is outstanding.
  assign mem_valid = (state_q == REQ);
  assign mem_we    = mem_valid & cmd_q.we;
  assign mem_addr  = mem_valid ? {cmd_q.addr[31:2], 2'b00} : 32'h0;
  assign mem_be    = mem_valid ? be_w : 4'h0;
  assign mem_wdata = mem_valid ? wdata_w : 32'h0;
  assign ReadData  = rdata_q;
  assign BusErr    = bus_err_q;

  // Next-state, command latch, timeout counter and Stall.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    bus_err_d = 1'b0;
    Stall     = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = 16'h0;
        if (MemRead || MemWrite) begin
          Stall = 1'b1;
          // A simultaneous read request is dropped: the store wins.
          cmd_d = '{we: MemWrite, funct3: Funct3, addr: Addr, wdata: WriteData};
          state_d = REQ;
`ifdef MISALIGN_TRAP_EN
          if (is_misaligned(Funct3, Addr[1:0])) begin
            state_d   = DONE;
            mis_err_d = 1'b1;
          end
`endif
        end
      end
      REQ: begin
        Stall = 1'b1;
        cnt_d = cnt_inc;
        if (mem_ready) begin
          state_d = cmd_q.we ? DONE : WAIT;
        end else if (timeout) begin
          state_d   = DONE;
          bus_err_d = 1'b1;
        end
      end
      WAIT: begin
        Stall = 1'b1;
        cnt_d = cnt_inc;
        if (mem_rvalid) begin
          rdata_d = load_w;
          state_d = DONE;
        end else if (timeout) begin
          state_d   = DONE;
          bus_err_d = 1'b1;
        end
      end
      DONE: begin
        // Load data is only presented for the single retire cycle.
        rdata_d = 32'h0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      cnt_q     <= 16'h0;
      rdata_q   <= 32'h0;
      bus_err_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
`ifdef MISALIGN_TRAP_EN
      mis_err_q <= mis_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge using an expected-result queue.
module tb_lsu_bus_bridge;
  import lsu_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, WriteData, ReadData;
  logic        Stall, BusErr, MisalignErr;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int          stall;
    int          vcyc;
    logic [3:0]  be;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stable;
    logic [31:0] rdata;
    logic        berr;
    logic        merr;
  } res_t;

  res_t sb_q[$];

  always #5 clk = ~clk;

  lsu_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Funct3      (Funct3),
    .Addr        (Addr),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .Stall       (Stall),
    .BusErr      (BusErr),
    .MisalignErr (MisalignErr),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  // Reference lane model.
  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000, 3'b100: return 4'b0001 << off;
      3'b001, 3'b101: return off[1] ? 4'b1100 : 4'b0011;
      default:        return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000, 3'b100: return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      3'b001, 3'b101: return {wd[15:0], wd[15:0]};
      default:        return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] sh;
    case (f3)
      3'b000: begin sh = rd >> (8 * off); return {{24{sh[7]}}, sh[7:0]}; end
      3'b100: begin sh = rd >> (8 * off); return {24'h0, sh[7:0]}; end
      3'b001: begin sh = rd >> (off[1] ? 16 : 0); return {{16{sh[15]}}, sh[15:0]}; end
      3'b101: begin sh = rd >> (off[1] ? 16 : 0); return {16'h0, sh[15:0]}; end
      default: return rd;
    endcase
  endfunction

  // Drives one access, plays the memory side, and records what the DUT did.
  // Ends at the DONE cycle with the command still asserted.
  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input int rdy_dly, input int rv_dly,
                        output res_t o);
    int vcount = 0;
    int wcount = 0;
    bit hs = 0;
    bit done = 0;
    bit first = 1;
    o = '{default: 0};
    o.stable = 1'b1;
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WriteData = wd;
    mem_rdata = rdat; mem_ready = 1'b0; mem_rvalid = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (!Stall) begin
        done = 1;
        o.rdata = ReadData; o.berr = BusErr; o.merr = MisalignErr;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
      end else begin
        o.stall++;
        if (hs) begin
          mem_ready  = 1'b0;
          mem_rvalid = (rv_dly >= 0 && wcount == rv_dly);
          wcount++;
        end
        if (mem_valid) begin
          vcount++;
          if (first) begin
            o.be = mem_be; o.we = mem_we; o.addr = mem_addr; o.wdata = mem_wdata;
            first = 0;
          end else if ({mem_be, mem_we, mem_addr, mem_wdata} !== {o.be, o.we, o.addr, o.wdata}) begin
            o.stable = 1'b0;
          end
          if (vcount - 1 == rdy_dly) begin
            mem_ready = 1'b1;
            hs = 1;
          end
        end
      end
    end
    o.vcyc = vcount;
    if (!done) begin
      n_total++;
      $display("FAIL %s_done: no DONE cycle within 40 cycles", name);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b0; Addr = 32'h0;
    WriteData = 32'h0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({ReadData, Stall, BusErr, MisalignErr, mem_valid, mem_we, mem_addr, mem_be, mem_wdata} !== '0)
      $display("FAIL reset_outputs got rd=%h st=%b be=%b mv=%b addr=%h wd=%h required all 0",
               ReadData, Stall, mem_be, mem_valid, mem_addr, mem_wdata);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_load_byte();
    res_t o, e;
    e = '{default: 0};
    e.stall = 3; e.be = 4'b1000; e.addr = 32'h100; e.rdata = 32'hFFFF_FF80;
    sb_q.push_back(e);
    access("lb", 1, 0, F3_LB, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, o);
    e = sb_q.pop_front();
    n_total++; if (o.be !== e.be) $display("FAIL lb_be got %b exp %b", o.be, e.be); else n_pass++;
    n_total++; if (o.addr !== e.addr) $display("FAIL lb_addr got %h exp %h", o.addr, e.addr); else n_pass++;
    n_total++; if (o.rdata !== e.rdata) $display("FAIL lb_rdata got %h exp %h", o.rdata, e.rdata); else n_pass++;
    n_total++; if (o.stall != e.stall) $display("FAIL lb_stall got %0d exp %0d", o.stall, e.stall); else n_pass++;
    n_total++; if (o.we !== 1'b0) $display("FAIL lb_we got %b exp 0", o.we); else n_pass++;
    idle();
    @(negedge clk);
    n_total++; if (ReadData !== 32'h0) $display("FAIL lb_rdata_after got %h exp 0", ReadData); else n_pass++;
  endtask

  task automatic test_load_half();
    res_t o, e;
    e = '{default: 0};
    e.be = 4'b1100; e.rdata = 32'h0000_8001; e.stall = 3;
    sb_q.push_back(e);
    access("lhu", 1, 0, F3_LHU, 32'h102, 32'h0, 32'h8001_0000, 0, 0, o);
    e = sb_q.pop_front();
    n_total++; if (o.be !== e.be) $display("FAIL lhu_be got %b exp %b", o.be, e.be); else n_pass++;
    n_total++; if (o.rdata !== e.rdata) $display("FAIL lhu_rdata got %h exp %h", o.rdata, e.rdata); else n_pass++;
    n_total++; if (o.stall != e.stall) $display("FAIL lhu_stall got %0d exp %0d", o.stall, e.stall); else n_pass++;
    idle();
  endtask

  task automatic test_store_byte();
    res_t o, e;
    e = '{default: 0};
    e.wdata = 32'hABAB_ABAB; e.be = 4'b0010; e.vcyc = 5; e.stall = 6; e.we = 1'b1; e.addr = 32'h200;
    sb_q.push_back(e);
    access("sb", 0, 1, F3_LB, 32'h201, 32'h0000_00AB, 32'hDEAD_BEEF, 4, -1, o);
    e = sb_q.pop_front();
    n_total++; if (o.wdata !== e.wdata) $display("FAIL sb_wdata got %h exp %h", o.wdata, e.wdata); else n_pass++;
    n_total++; if (o.be !== e.be) $display("FAIL sb_be got %b exp %b", o.be, e.be); else n_pass++;
    n_total++; if (o.vcyc != e.vcyc) $display("FAIL sb_valid_cycles got %0d exp %0d", o.vcyc, e.vcyc); else n_pass++;
    n_total++; if (o.stable !== 1'b1) $display("FAIL sb_stable got %b exp 1", o.stable); else n_pass++;
    n_total++; if (o.stall != e.stall) $display("FAIL sb_stall got %0d exp %0d", o.stall, e.stall); else n_pass++;
    n_total++; if ({o.we, o.addr} !== {e.we, e.addr}) $display("FAIL sb_we_addr got %b/%h exp %b/%h", o.we, o.addr, e.we, e.addr); else n_pass++;
    idle();
  endtask

  task automatic test_timeout();
    res_t o, e;
    // Response never arrives: 1 REQ cycle + 7 WAIT cycles, then DONE.
    e = '{default: 0};
    e.stall = 1 + TO; e.berr = 1'b1; e.rdata = 32'h0; e.vcyc = 1;
    sb_q.push_back(e);
    access("to_wait", 1, 0, F3_LW, 32'h40, 32'h0, 32'h1234_5678, 0, -1, o);
    e = sb_q.pop_front();
    n_total++; if (o.stall != e.stall) $display("FAIL to_wait_stall got %0d exp %0d", o.stall, e.stall); else n_pass++;
    n_total++; if (o.berr !== e.berr) $display("FAIL to_wait_buserr got %b exp %b", o.berr, e.berr); else n_pass++;
    n_total++; if (o.rdata !== e.rdata) $display("FAIL to_wait_rdata got %h exp %h", o.rdata, e.rdata); else n_pass++;
    idle();
    @(negedge clk);
    n_total++; if (BusErr !== 1'b0) $display("FAIL to_buserr_pulse got %b exp 0", BusErr); else n_pass++;
    // Request never accepted: mem_valid held for all 8 cycles then dropped.
    e = '{default: 0};
    e.stall = 1 + TO; e.berr = 1'b1; e.vcyc = TO;
    sb_q.push_back(e);
    access("to_req", 1, 0, F3_LW, 32'h44, 32'h0, 32'h0, -1, -1, o);
    e = sb_q.pop_front();
    n_total++; if (o.vcyc != e.vcyc) $display("FAIL to_req_valid_cycles got %0d exp %0d", o.vcyc, e.vcyc); else n_pass++;
    n_total++; if (o.berr !== e.berr) $display("FAIL to_req_buserr got %b exp %b", o.berr, e.berr); else n_pass++;
    n_total++; if (mem_valid !== 1'b0) $display("FAIL to_req_valid_drop got %b exp 0", mem_valid); else n_pass++;
    idle();
  endtask

  task automatic test_rw_conflict();
    res_t o, e;
    e = '{default: 0};
    e.we = 1'b1; e.be = 4'b1111; e.wdata = 32'h1234_5678; e.addr = 32'h300; e.stall = 2;
    sb_q.push_back(e);
    access("rw", 1, 1, F3_LW, 32'h300, 32'h1234_5678, 32'h0, 0, 0, o);
    e = sb_q.pop_front();
    n_total++; if ({o.we, o.be} !== {e.we, e.be}) $display("FAIL rw_we_be got %b/%b exp %b/%b", o.we, o.be, e.we, e.be); else n_pass++;
    n_total++; if ({o.addr, o.wdata} !== {e.addr, e.wdata}) $display("FAIL rw_addr_wdata got %h/%h exp %h/%h", o.addr, o.wdata, e.addr, e.wdata); else n_pass++;
    n_total++; if (o.stall != e.stall) $display("FAIL rw_stall got %0d exp %0d", o.stall, e.stall); else n_pass++;
    idle();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    MemRead = 1'b1; Funct3 = F3_LW; Addr = 32'h10; mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);            // IDLE
    @(negedge clk);            // REQ
    mem_ready = 1'b1;
    @(negedge clk);            // WAIT
    mem_ready = 1'b0;
    n_total++; if (Stall !== 1'b1) $display("FAIL rst_mid_wait_stall got %b exp 1", Stall); else n_pass++;
    reset = 1'b1; MemRead = 1'b0;
    @(negedge clk);
    n_total++;
    if ({ReadData, Stall, BusErr, MisalignErr, mem_valid, mem_we, mem_addr, mem_be, mem_wdata} !== '0)
      $display("FAIL rst_mid_outputs got st=%b mv=%b addr=%h be=%b required all 0", Stall, mem_valid, mem_addr, mem_be);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_misalign();
    res_t o, e;
    e = '{default: 0};
`ifdef MISALIGN_TRAP_EN
    e.merr = 1'b1; e.vcyc = 0; e.rdata = 32'h0; e.stall = 1;
`else
    e.addr = 32'h100; e.be = 4'b1111; e.rdata = 32'hCAFE_F00D; e.vcyc = 1; e.stall = 3;
`endif
    sb_q.push_back(e);
    access("mis", 1, 0, F3_LW, 32'h102, 32'h0, 32'hCAFE_F00D, 0, 0, o);
    e = sb_q.pop_front();
    n_total++; if (o.merr !== e.merr) $display("FAIL mis_err got %b exp %b", o.merr, e.merr); else n_pass++;
    n_total++; if (o.vcyc != e.vcyc) $display("FAIL mis_valid_cycles got %0d exp %0d", o.vcyc, e.vcyc); else n_pass++;
    n_total++; if (o.rdata !== e.rdata) $display("FAIL mis_rdata got %h exp %h", o.rdata, e.rdata); else n_pass++;
    n_total++; if ({o.addr, o.be} !== {e.addr, e.be}) $display("FAIL mis_addr_be got %h/%b exp %h/%b", o.addr, o.be, e.addr, e.be); else n_pass++;
    idle();
  endtask

  task automatic test_back_to_back();
    res_t o, e;
    e = '{default: 0};
    e.rdata = 32'h0000_0080; e.be = 4'b0100; e.stall = 3;
    sb_q.push_back(e);
    e = '{default: 0};
    e.we = 1'b1; e.be = 4'b1100; e.wdata = 32'hBEEF_BEEF; e.addr = 32'h4; e.stall = 2;
    sb_q.push_back(e);
    access("b2b_ld", 1, 0, F3_LBU, 32'h2, 32'h0, 32'h0080_0000, 0, 0, o);
    e = sb_q.pop_front();
    n_total++; if ({o.rdata, o.be} !== {e.rdata, e.be}) $display("FAIL b2b_ld got %h/%b exp %h/%b", o.rdata, o.be, e.rdata, e.be); else n_pass++;
    n_total++; if (o.stall != e.stall) $display("FAIL b2b_ld_stall got %0d exp %0d", o.stall, e.stall); else n_pass++;
    access("b2b_st", 0, 1, F3_LH, 32'h6, 32'h0000_BEEF, 32'h0, 0, 0, o);
    e = sb_q.pop_front();
    n_total++; if ({o.we, o.be, o.addr, o.wdata} !== {e.we, e.be, e.addr, e.wdata})
      $display("FAIL b2b_st got %b/%b/%h/%h exp %b/%b/%h/%h", o.we, o.be, o.addr, o.wdata, e.we, e.be, e.addr, e.wdata);
    else n_pass++;
    n_total++; if (o.stall != e.stall) $display("FAIL b2b_st_stall got %0d exp %0d", o.stall, e.stall); else n_pass++;
    idle();
  endtask

  task automatic test_random();
    logic [2:0] f3_tab [5];
    f3_tab[0] = F3_LB; f3_tab[1] = F3_LH; f3_tab[2] = F3_LW; f3_tab[3] = F3_LBU; f3_tab[4] = F3_LHU;
    for (int i = 0; i < 12; i++) begin
      res_t o, e;
      logic [2:0]  f3;
      logic [31:0] a, wd, rd;
      logic        is_wr;
      int          rdy, rv;
      f3    = f3_tab[$urandom_range(0, 4)];
      a     = $urandom;
      if (f3[0]) a[0] = 1'b0;
      if (f3 == F3_LW) a[1:0] = 2'b00;
      wd    = $urandom;
      rd    = $urandom;
      is_wr = 1'($urandom_range(0, 1));
      if (is_wr && f3[2]) f3 = {1'b0, f3[1:0]};
      rdy   = $urandom_range(0, 2);
      rv    = $urandom_range(0, 2);
      e = '{default: 0};
      e.be = m_be(f3, a[1:0]); e.we = is_wr; e.addr = {a[31:2], 2'b00};
      e.wdata = m_wd(f3, wd);
      e.rdata = is_wr ? 32'h0 : m_ld(f3, a[1:0], rd);
      e.stall = is_wr ? 2 + rdy : 3 + rdy + rv;
      sb_q.push_back(e);
      access("rnd", !is_wr, is_wr, f3, a, wd, rd, rdy, rv, o);
      e = sb_q.pop_front();
      n_total++;
      if ({o.be, o.we, o.addr} !== {e.be, e.we, e.addr})
        $display("FAIL rnd%0d_req got %b/%b/%h exp %b/%b/%h", i, o.be, o.we, o.addr, e.be, e.we, e.addr);
      else n_pass++;
      n_total++;
      if (is_wr ? (o.wdata !== e.wdata) : (o.rdata !== e.rdata))
        $display("FAIL rnd%0d_data f3=%b got wd=%h rd=%h exp wd=%h rd=%h", i, f3, o.wdata, o.rdata, e.wdata, e.rdata);
      else n_pass++;
      n_total++;
      if (o.stall != e.stall) $display("FAIL rnd%0d_stall got %0d exp %0d", i, o.stall, e.stall); else n_pass++;
      idle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_byte();
    test_load_half();
    test_store_byte();
    test_timeout();
    test_rw_conflict();
    test_reset_mid();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
